// File: rtl/frontend_pkg.sv
// Shared frontend types: XLEN, the fetched {pc, instr} entry and default fetch width.
package frontend_pkg;
  localparam int XLEN        = 32;
  localparam int FETCH_WIDTH = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_lane_compact.sv
// Packs the valid lanes of a fetch group into slots 0..n-1 (ascending lane order) and counts them.
module fetch_lane_compact
  import frontend_pkg::*;
#(
  parameter int FETCH_W = FETCH_WIDTH,
  parameter int NW      = $clog2(FETCH_W + 1)
) (
  input  logic         [FETCH_W-1:0] valid,
  input  fetch_entry_t [FETCH_W-1:0] lane,
  output fetch_entry_t [FETCH_W-1:0] cmp,
  output logic         [NW-1:0]      num
);

  logic [FETCH_W-1:0][NW-1:0] pre;
  logic [NW-1:0]              acc;

  always_comb begin
    pre = '0;
    acc = '0;
    cmp = '0;
    // pre[j] is the slot a valid lane j lands in: the number of valid lanes below it
    for (int j = 0; j < FETCH_W; j++) begin
      pre[j] = acc;
      acc    = acc + NW'(valid[j]);
    end
    num = acc;
    for (int k = 0; k < FETCH_W; k++)
      for (int j = 0; j < FETCH_W; j++)
        if (valid[j] && pre[j] == NW'(k)) cmp[k] = lane[j];
  end

endmodule

// File: rtl/fetch_queue.sv
// In-order fetch->decode buffer: compacted multi-lane enqueue, thermometer dequeue, flush on redirect.
module fetch_queue
  import frontend_pkg::*;
#(
  parameter int FETCH_W = FETCH_WIDTH,
  parameter int DEC_W   = 2,
  parameter int DEPTH   = 8,
  parameter int XLEN    = frontend_pkg::XLEN
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [FETCH_W-1:0]                enq_valid,
  input  logic [FETCH_W-1:0][XLEN-1:0]      enq_pc,
  input  logic [FETCH_W-1:0][XLEN-1:0]      enq_instr,
  output logic                              enq_ready,
  output logic [DEC_W-1:0]                  deq_valid,
  output logic [DEC_W-1:0][XLEN-1:0]        deq_pc,
  output logic [DEC_W-1:0][XLEN-1:0]        deq_instr,
  input  logic [$clog2(DEC_W+1)-1:0]        deq_take,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              empty,
  output logic                              full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(FETCH_W + 1);

  fetch_entry_t                mem [DEPTH];
  logic         [PW-1:0]       rd_ptr, wr_ptr;
  logic         [CW-1:0]       count_q, take_n, enq_add;
  fetch_entry_t [FETCH_W-1:0]  lane, cmp;
  logic         [NW-1:0]       enq_n;
  logic                        enq_fire;

  for (genvar i = 0; i < FETCH_W; i++) begin : g_lane
    assign lane[i].pc    = enq_pc[i];
    assign lane[i].instr = enq_instr[i];
  end

  fetch_lane_compact #(.FETCH_W(FETCH_W), .NW(NW)) u_compact (
    .valid (enq_valid),
    .lane  (lane),
    .cmp   (cmp),
    .num   (enq_n)
  );

  // Space check uses current occupancy only; a same-cycle dequeue never frees room
  assign enq_ready = (CW'(DEPTH) - count_q) >= CW'(FETCH_W);
  assign enq_fire  = enq_ready && (|enq_valid);
  assign enq_add   = enq_fire ? CW'(enq_n) : '0;
  assign take_n    = (CW'(deq_take) > count_q) ? count_q : CW'(deq_take);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      rd_ptr  <= rd_ptr + PW'(take_n);
      wr_ptr  <= wr_ptr + PW'(enq_add);
      count_q <= count_q + enq_add - take_n;
    end
  end

  // Storage is left unreset; the pointers alone decide what is reachable
  always_ff @(posedge clk) begin
    if (enq_fire && !flush)
      for (int k = 0; k < FETCH_W; k++)
        if (NW'(k) < enq_n) mem[wr_ptr + PW'(k)] <= cmp[k];
  end

  for (genvar i = 0; i < DEC_W; i++) begin : g_deq
    fetch_entry_t ent;
    assign ent          = mem[rd_ptr + PW'(i)];
    assign deq_valid[i] = count_q > CW'(i);
    assign deq_pc[i]    = deq_valid[i] ? ent.pc    : '0;
    assign deq_instr[i] = deq_valid[i] ? ent.instr : '0;
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Scenario bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  localparam int FETCH_W = 2;
  localparam int DEC_W   = 2;
  localparam int DEPTH   = 8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     flush;
  logic [FETCH_W-1:0]       enq_valid;
  logic [FETCH_W-1:0][31:0] enq_pc;
  logic [FETCH_W-1:0][31:0] enq_instr;
  logic                     enq_ready;
  logic [DEC_W-1:0]         deq_valid;
  logic [DEC_W-1:0][31:0]   deq_pc;
  logic [DEC_W-1:0][31:0]   deq_instr;
  logic [1:0]               deq_take;
  logic [3:0]               count;
  logic                     empty;
  logic                     full;

  int   vectors = 0;
  int   miscompares = 0;
  ent_t q[$];

  fetch_queue #(.FETCH_W(FETCH_W), .DEC_W(DEC_W), .DEPTH(DEPTH), .XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_pc    (enq_pc),
    .enq_instr (enq_instr),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_pc    (deq_pc),
    .deq_instr (deq_instr),
    .deq_take  (deq_take),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  // Advance one edge, update the reference model from the applied inputs, return at negedge.
  task automatic tick();
    int   tk;
    bit   rdy;
    ent_t e;
    @(posedge clk);
    if (!reset || flush) q.delete();
    else begin
      rdy = (DEPTH - q.size()) >= FETCH_W;
      tk  = int'(deq_take);
      if (tk > q.size()) tk = q.size();
      repeat (tk) void'(q.pop_front());
      if (rdy)
        for (int i = 0; i < FETCH_W; i++)
          if (enq_valid[i]) begin
            e.pc = enq_pc[i]; e.instr = enq_instr[i];
            q.push_back(e);
          end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [1:0] take);
    enq_valid    = v;
    enq_pc[0]    = pc0;
    enq_pc[1]    = pc1;
    enq_instr[0] = $urandom;
    enq_instr[1] = $urandom;
    deq_take     = take;
  endtask

  task automatic drain();
    drive(2'b00, 0, 0, 2'd2);
    for (int n = 0; n < 10 && q.size() != 0; n++) tick();
    deq_take = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0;
    drive(2'b00, 0, 0, 2'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (empty !== 1'b1)     begin miscompares++; $display("FAIL reset_empty got %0b want 1", empty); end
    vectors++; if (enq_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %0b want 1", enq_ready); end
    vectors++; if (deq_valid !== 2'b00) begin miscompares++; $display("FAIL reset_deq_valid got %b want 00", deq_valid); end
    vectors++; if (deq_pc !== '0)      begin miscompares++; $display("FAIL reset_deq_pc got %h want 0", deq_pc); end
    vectors++; if (full !== 1'b0)      begin miscompares++; $display("FAIL reset_full got %0b want 0", full); end
    drive(2'b00, 0, 0, 2'd2);
    tick();
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL empty_take count got %0d want 0", count); end
    deq_take = 0;
  endtask

  task automatic test_basic();
    drive(2'b11, 32'h0, 32'h4, 2'd0); tick();
    drive(2'b11, 32'h8, 32'hC, 2'd0); tick();
    drive(2'b00, 0, 0, 2'd0);
    vectors++; if (count !== 4'd4) begin miscompares++; $display("FAIL basic_count got %0d want 4", count); end
    vectors++; if (deq_pc[0] !== 32'h0 || deq_pc[1] !== 32'h4)
      begin miscompares++; $display("FAIL basic_head got %h,%h want 0,4", deq_pc[0], deq_pc[1]); end
    deq_take = 2'd1; tick(); deq_take = 2'd0;
    vectors++; if (deq_pc[0] !== 32'h4 || deq_pc[1] !== 32'h8)
      begin miscompares++; $display("FAIL basic_take1 got %h,%h want 4,8", deq_pc[0], deq_pc[1]); end
    vectors++; if (count !== 4'd3) begin miscompares++; $display("FAIL basic_count3 got %0d want 3", count); end
    drain();
  endtask

  task automatic test_sparse();
    drive(2'b10, 32'hDEAD, 32'h14, 2'd0); tick();
    drive(2'b00, 0, 0, 2'd0);
    vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL sparse_count got %0d want 1", count); end
    vectors++; if (deq_valid !== 2'b01) begin miscompares++; $display("FAIL sparse_valid got %b want 01", deq_valid); end
    vectors++; if (deq_pc[0] !== 32'h14 || deq_pc[1] !== 32'h0)
      begin miscompares++; $display("FAIL sparse_pc got %h,%h want 14,0", deq_pc[0], deq_pc[1]); end
    drain();
  endtask

  task automatic test_fill();
    for (int n = 0; n < 4; n++) begin
      vectors++; if (enq_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready count=%0d got 0 want 1", count); end
      drive(2'b11, 32'h200 + 8*n, 32'h204 + 8*n, 2'd0); tick();
    end
    vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL fill_count got %0d want 8", count); end
    vectors++; if (full !== 1'b1 || enq_ready !== 1'b0)
      begin miscompares++; $display("FAIL fill_full full=%0b ready=%0b want 1,0", full, enq_ready); end
    drive(2'b11, 32'hBAD0, 32'hBAD4, 2'd0); tick();
    vectors++; if (count !== 4'd8 || deq_pc[0] !== 32'h200)
      begin miscompares++; $display("FAIL fill_ignored count=%0d head=%h want 8,200", count, deq_pc[0]); end
    drain();
    drive(2'b01, 32'h300, 0, 2'd0); tick();
    for (int n = 0; n < 3; n++) begin drive(2'b11, 32'h304 + 8*n, 32'h308 + 8*n, 2'd0); tick(); end
    vectors++; if (count !== 4'd7 || enq_ready !== 1'b0 || full !== 1'b0)
      begin miscompares++; $display("FAIL fill7 count=%0d ready=%0b full=%0b want 7,0,0", count, enq_ready, full); end
    drive(2'b01, 32'hBAD8, 0, 2'd0); tick();
    vectors++; if (count !== 4'd7) begin miscompares++; $display("FAIL fill7_ignored count got %0d want 7", count); end
    drain();
  endtask

  task automatic test_wrap();
    logic [31:0] next_pc, exp_head;
    drive(2'b11, 32'h0, 32'h4, 2'd0); tick();
    next_pc = 32'h8; exp_head = 32'h0;
    for (int n = 0; n < 10; n++) begin
      vectors++; if (deq_pc[0] !== exp_head || deq_pc[1] !== exp_head + 4 || count !== 4'd2)
        begin miscompares++;
          $display("FAIL wrap cycle %0d got %h,%h cnt %0d want %h,%h cnt 2", n, deq_pc[0], deq_pc[1], count, exp_head, exp_head + 4); end
      drive(2'b11, next_pc, next_pc + 4, 2'd2); tick();
      next_pc += 8; exp_head += 8;
    end
    drain();
  endtask

  task automatic test_flush();
    drive(2'b11, 32'h500, 32'h504, 2'd0); tick();
    drive(2'b11, 32'h508, 32'h50C, 2'd0); tick();
    drive(2'b01, 32'h510, 0, 2'd0); tick();
    vectors++; if (count !== 4'd5) begin miscompares++; $display("FAIL flush_setup count got %0d want 5", count); end
    flush = 1'b1; drive(2'b11, 32'hF00, 32'hF04, 2'd2); tick(); flush = 1'b0;
    drive(2'b00, 0, 0, 2'd0);
    vectors++; if (count !== 4'd0 || empty !== 1'b1)
      begin miscompares++; $display("FAIL flush_clear count=%0d empty=%0b want 0,1", count, empty); end
    drive(2'b11, 32'h100, 32'h104, 2'd0); tick(); deq_take = 0;
    vectors++; if (deq_pc[0] !== 32'h100 || deq_pc[1] !== 32'h104)
      begin miscompares++; $display("FAIL flush_after got %h,%h want 100,104", deq_pc[0], deq_pc[1]); end
    drain();
  endtask

  task automatic test_reset_mid();
    drive(2'b11, 32'h600, 32'h604, 2'd0); tick();
    drive(2'b11, 32'h608, 32'h60C, 2'd0); tick();
    drive(2'b01, 32'h610, 0, 2'd0); tick();
    drive(2'b11, 32'hE00, 32'hE04, 2'd2);
    reset = 1'b0; q.delete();
    #1;
    vectors++; if (count !== 4'd0 || empty !== 1'b1 || deq_valid !== 2'b00 || deq_pc !== '0 || enq_ready !== 1'b1)
      begin miscompares++;
        $display("FAIL reset_mid count=%0d empty=%0b valid=%b ready=%0b want 0,1,00,1", count, empty, deq_valid, enq_ready); end
    tick();
    reset = 1'b1;
    drive(2'b00, 0, 0, 2'd0); tick();
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_mid_hold count got %0d want 0", count); end
  endtask

  task automatic test_random();
    logic [DEC_W-1:0]       ev;
    logic [DEC_W-1:0][31:0] ep, ei;
    logic [31:0]            pc = 32'h1000;
    for (int n = 0; n < 300; n++) begin
      ev = '0; ep = '0; ei = '0;
      for (int i = 0; i < DEC_W; i++)
        if (i < q.size()) begin ev[i] = 1'b1; ep[i] = q[i].pc; ei[i] = q[i].instr; end
      vectors++; if (deq_valid !== ev) begin miscompares++; $display("FAIL rnd_valid %0d got %b want %b", n, deq_valid, ev); end
      vectors++; if (deq_pc !== ep) begin miscompares++; $display("FAIL rnd_pc %0d got %h want %h", n, deq_pc, ep); end
      vectors++; if (deq_instr !== ei) begin miscompares++; $display("FAIL rnd_instr %0d got %h want %h", n, deq_instr, ei); end
      vectors++; if (count !== 4'(q.size())) begin miscompares++; $display("FAIL rnd_count %0d got %0d want %0d", n, count, q.size()); end
      vectors++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH) || enq_ready !== ((DEPTH - q.size()) >= FETCH_W))
        begin miscompares++; $display("FAIL rnd_flags %0d got e%0b f%0b r%0b size %0d", n, empty, full, enq_ready, q.size()); end
      flush = ($urandom_range(0, 19) == 0);
      drive(2'($urandom), pc, pc + 4, 2'($urandom_range(0, DEC_W)));
      pc += 8;
      tick();
    end
    flush = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sparse();
    test_fill();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
